uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 154 +++++++++++++++
 tb/tb_uart_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx - 8N1 UART receiver with mid-bit sampling.
//
// Recovers frames of 1 start bit, 8 data bits (LSB first) and 1 stop bit from
// an asynchronous serial line. Bit timing comes from a divide-by-BAUD_CNT
// counter. The start bit is re-checked at half a bit, and every later bit is
// sampled once at its nominal centre. There is no oversampling vote.
//
// Parameters
//   BAUD_CNT      clock cycles per bit (>= 4)
// Ports
//   clk           system clock, rising edge
//   rst           asynchronous active-high reset
//   rx            serial line, idle high, asynchronous to clk
//   rx_data       last correctly received byte, held until the next good frame
//   rx_valid      one-cycle pulse, rx_data updated this cycle
//   rx_frame_err  one-cycle pulse, stop bit sampled low, byte discarded
//   rx_busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_rx #(
  parameter int BAUD_CNT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  output logic       rx_busy
);

  localparam int CW = (BAUD_CNT > 1) ? $clog2(BAUD_CNT) : 1;
  localparam logic [CW-1:0] LAST_C = CW'(BAUD_CNT - 1);
  localparam logic [CW-1:0] HALF_C = CW'(BAUD_CNT / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // Two-flop synchronizer plus one delay flop for falling-edge detection.
  // All three flops reset to 1 (line idle), so no edge is seen out of reset.
  logic rx_meta_q, rx_s_q, rx_dly_q;
  logic start_edge;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_dly_q  <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      rx_dly_q  <= rx_s_q;
    end
  end

  // A new frame needs a genuine high-to-low transition. A line held low after
  // a frame error or break cannot retrigger the receiver.
  assign start_edge = rx_dly_q & ~rx_s_q;

  state_t         state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     idx_q;
  logic [7:0]     shift_q;
  logic [7:0]     rx_data_q;
  logic           rx_valid_q;
  logic           rx_frame_err_q;
  logic           rx_busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      idx_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;
      rx_busy_q      <= 1'b0;
    end else begin
      // Pulses last a single cycle unless re-asserted below.
      rx_valid_q     <= 1'b0;
      rx_frame_err_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_edge) begin
            state_q   <= START;
            rx_busy_q <= 1'b1;
          end
        end

        START: begin
          if (cnt_q == HALF_C) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              // The line went high again before mid start bit, so this was a
              // glitch. Drop back without any pulse.
              state_q   <= IDLE;
              rx_busy_q <= 1'b0;
            end else begin
              state_q <= DATA;
              idx_q   <= '0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        DATA: begin
          if (cnt_q == LAST_C) begin
            cnt_q          <= '0;
            shift_q[idx_q] <= rx_s_q;
            if (idx_q == 3'd7) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        STOP: begin
          if (cnt_q == LAST_C) begin
            cnt_q     <= '0;
            state_q   <= IDLE;
            rx_busy_q <= 1'b0;
            if (rx_s_q) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              rx_frame_err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_busy      = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx - directed self-checking bench for uart_rx.
//
// Three receivers (BAUD_CNT = 16, 4 and 17) share one serial line and one
// reset. Each test drives frames at the bit rate of one instance and checks
// only that instance's outputs. The other instances see garbage, and the bench
// leaves long idle gaps so they settle before their own tests.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;

  logic [7:0] d16, d4, d17;
  logic       v16, v4, v17;
  logic       e16, e4, e17;
  logic       b16, b4, b17;

  always #5 clk = ~clk;

  uart_rx #(.BAUD_CNT(16)) u_rx16 (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(d16), .rx_valid(v16), .rx_frame_err(e16), .rx_busy(b16)
  );
  uart_rx #(.BAUD_CNT(4)) u_rx4 (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(d4), .rx_valid(v4), .rx_frame_err(e4), .rx_busy(b4)
  );
  uart_rx #(.BAUD_CNT(17)) u_rx17 (
    .clk(clk), .rst(rst), .rx(rx),
    .rx_data(d17), .rx_valid(v17), .rx_frame_err(e17), .rx_busy(b17)
  );

  // Cycle counter and output monitors, sampled on the falling edge.
  int cyc    = 0;
  int vc16   = 0;
  int ec16   = 0;
  int bc16   = 0;
  int vcyc16 = 0;
  int vc4    = 0;
  int vc17   = 0;
  int both   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v16) begin
      vc16   <= vc16 + 1;
      vcyc16 <= cyc;
    end
    if (e16) ec16 <= ec16 + 1;
    if (b16) bc16 <= bc16 + 1;
    if (v4)  vc4  <= vc4 + 1;
    if (v17) vc17 <= vc17 + 1;
    if ((v16 & e16) | (v4 & e4) | (v17 & e17)) both <= both + 1;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input real bit_ns, input logic [7:0] d, input logic stop);
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      #(bit_ns);
    end
    rx = stop;
    #(bit_ns);
  endtask

  int s_cyc, s_vc, s_ec, s_bc, s_vc4, s_vc17, t_first;

  initial begin
    // Reset state
    wait_cyc(3);
    check_eq("reset_data", int'(d16), 'h00);
    check_eq("reset_valid", int'(v16), 0);
    check_eq("reset_ferr", int'(e16), 0);
    check_eq("reset_busy", int'(b16), 0);
    rst = 1'b0;
    wait_cyc(20);

    // Single ideal frame 0x55: one pulse, latency, busy duration
    align();
    s_cyc = cyc; s_vc = vc16; s_ec = ec16; s_bc = bc16;
    send_byte(160.0, 8'h55, 1'b1);
    wait_cyc(20);
    check_eq("b16_55_cnt", vc16 - s_vc, 1);
    check_eq("b16_55_data", int'(d16), 'h55);
    check_eq("b16_55_noerr", ec16 - s_ec, 0);
    check_eq("b16_55_busy", bc16 - s_bc, 8 + 9 * 16);
    check_eq("b16_55_lat", vcyc16 - s_cyc, 155);

    // Back-to-back frames with zero idle bits
    align();
    s_vc = vc16;
    send_byte(160.0, 8'hA5, 1'b1);
    check_eq("b2b_first", int'(d16), 'hA5);
    t_first = vcyc16;
    send_byte(160.0, 8'h3C, 1'b1);
    wait_cyc(20);
    check_eq("b2b_second", int'(d16), 'h3C);
    check_eq("b2b_cnt", vc16 - s_vc, 2);
    check_eq("b2b_gap", vcyc16 - t_first, 160);

    // Short low glitch: false start, 8 cycles busy, no pulse
    align();
    s_vc = vc16; s_ec = ec16; s_bc = bc16;
    rx = 1'b0;
    wait_cyc(3);
    rx = 1'b1;
    wait_cyc(30);
    check_eq("glitch_busy", bc16 - s_bc, 8);
    check_eq("glitch_nov", vc16 - s_vc, 0);
    check_eq("glitch_noerr", ec16 - s_ec, 0);
    check_eq("glitch_data", int'(d16), 'h3C);

    // Frame error, then a break, then a good frame
    align();
    s_vc = vc16; s_ec = ec16;
    send_byte(160.0, 8'hF0, 1'b0);
    wait_cyc(40);
    rx = 1'b1;
    wait_cyc(40);
    check_eq("ferr_cnt", ec16 - s_ec, 1);
    check_eq("ferr_nov", vc16 - s_vc, 0);
    check_eq("ferr_data", int'(d16), 'h3C);
    align();
    send_byte(160.0, 8'h81, 1'b1);
    wait_cyc(20);
    check_eq("after_brk_data", int'(d16), 'h81);
    check_eq("after_brk_cnt", vc16 - s_vc, 1);

    // Reset during data bit 4 of 0xFF, then 0x12
    align();
    s_vc = vc16;
    rx = 1'b0;
    #160.0;
    rx = 1'b1;
    #720.0;
    rst = 1'b1;
    wait_cyc(2);
    check_eq("rst_mid_data", int'(d16), 'h00);
    check_eq("rst_mid_valid", int'(v16), 0);
    check_eq("rst_mid_busy", int'(b16), 0);
    rst = 1'b0;
    wait_cyc(200);
    check_eq("rst_abort_nov", vc16 - s_vc, 0);
    align();
    send_byte(160.0, 8'h12, 1'b1);
    wait_cyc(20);
    check_eq("post_rst_data", int'(d16), 'h12);
    check_eq("post_rst_cnt", vc16 - s_vc, 1);

    // BAUD_CNT = 4, extreme data patterns
    wait_cyc(100);
    align();
    s_vc4 = vc4;
    send_byte(40.0, 8'h00, 1'b1);
    wait_cyc(10);
    check_eq("b4_00_cnt", vc4 - s_vc4, 1);
    check_eq("b4_00_data", int'(d4), 'h00);
    align();
    send_byte(40.0, 8'hFF, 1'b1);
    wait_cyc(10);
    check_eq("b4_ff_cnt", vc4 - s_vc4, 2);
    check_eq("b4_ff_data", int'(d4), 'hFF);

    // BAUD_CNT = 17 with the line 3% slow, then 3% fast
    wait_cyc(200);
    align();
    s_vc17 = vc17;
    send_byte(175.1, 8'h69, 1'b1);
    wait_cyc(30);
    check_eq("b17_slow_cnt", vc17 - s_vc17, 1);
    check_eq("b17_slow_data", int'(d17), 'h69);
    align();
    send_byte(164.9, 8'h96, 1'b1);
    wait_cyc(30);
    check_eq("b17_fast_cnt", vc17 - s_vc17, 2);
    check_eq("b17_fast_data", int'(d17), 'h96);

    check_eq("valid_ferr_excl", both, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
